// File: rtl/pa_mem_pkg.sv
// pa_mem_pkg: shared definitions for the PA-RISC memory arbiter and the
// blocks built around it.
//   state_e    : arbiter FSM states
//   SZ_*       : access size codes carried on mem_size / ram_size
//   LAT_MIN/MAX: legal RAM read latency range
//   lat_to_cnt : clamps a latency parameter into the timer load value
package pa_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IF  = 2'd1,
    ST_BUSY_MEM = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;
  localparam int CNT_W   = 3;

  // Out-of-range latencies are pulled back into the supported window.
  function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
    if (lat < LAT_MIN) return CNT_W'(LAT_MIN);
    if (lat > LAT_MAX) return CNT_W'(LAT_MAX);
    return CNT_W'(lat);
  endfunction

endpackage

// File: rtl/pa_mem_arbiter_if.sv
// pa_mem_arbiter_if: bundle of the pipeline-side request/done signals and
// the RAM-side strobe/data signals of the memory arbiter.
//   slave  : arbiter view (requests and ram_rdata in, done/data and ram_* out)
//   master : pipeline + RAM view (the opposite directions)
// Handshake: a requester raises x_req with its address/data stable and holds
// all of them until it sees x_done high in a cycle; the access is complete in
// that cycle and x_rdata is valid only then. The arbiter never drops a held
// request. if_flush cancels an in-flight fetch: no if_done is produced for it.
interface pa_mem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [1:0]        ram_size;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_done, if_rdata,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output mem_done, mem_rdata,
    output ram_en, ram_we, ram_size, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_done, if_rdata,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  mem_done, mem_rdata,
    input  ram_en, ram_we, ram_size, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/pa_lat_timer.sv
// pa_lat_timer: loadable down-counter that flags when the count has expired.
//   clk, reset : clock, asynchronous active-high reset
//   i_load     : load i_val this edge (takes priority over counting)
//   i_val      : load value
//   o_last     : count is zero; the owner qualifies this with its own state
module pa_lat_timer
  import pa_mem_pkg::*;
#(
  parameter int CNT_W_P = CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [CNT_W_P-1:0] i_val,
  output logic               o_last
);

  logic [CNT_W_P-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/pa_mem_arbiter.sv
// pa_mem_arbiter: shares one fixed-latency RAM port between instruction
// fetch (IF) and the data stage (MEM).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pa_mem_arbiter_if.slave (requests, done/data, ram_* port)
//   o_state    : current FSM state, for observation
// Each access: grant edge -> one busy cycle with ram_en -> LAT more cycles,
// the last of which carries done and rdata -> one IDLE turnaround cycle.
module pa_mem_arbiter
  import pa_mem_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int LAT       = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  pa_mem_arbiter_if.slave     bus,
  output state_e              o_state
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  state_e            r_state;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [1:0]        r_ram_size;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [BW-1:0]     r_burst;
  logic              r_cancel;

  logic w_if_ok;
  logic w_if_prio;
  logic w_grant_mem;
  logic w_grant_if;
  logic w_last;

  // A flushed fetch is never granted; a starved IF overrides MEM priority.
  assign w_if_ok     = bus.if_req & ~bus.if_flush;
  assign w_if_prio   = w_if_ok & (r_burst == BURST_MAX);
  assign w_grant_mem = (r_state == ST_IDLE) & bus.mem_req & ~w_if_prio;
  assign w_grant_if  = (r_state == ST_IDLE) & w_if_ok & ~w_grant_mem;

  pa_lat_timer #(.CNT_W_P(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_grant_mem | w_grant_if),
    .i_val  (lat_to_cnt(LAT)),
    .o_last (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_size  <= 2'b00;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_burst     <= '0;
      r_cancel    <= 1'b0;
    end else begin
      // ram_en is a single-cycle strobe; the other ram_* fields stay latched
      // and are only meaningful alongside it.
      r_ram_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cancel <= 1'b0;
          if (w_grant_mem) begin
            r_state     <= ST_BUSY_MEM;
            r_ram_en    <= 1'b1;
            r_ram_we    <= bus.mem_we;
            r_ram_size  <= (bus.mem_size == 2'b11) ? SZ_WORD : bus.mem_size;
            r_ram_addr  <= bus.mem_addr;
            r_ram_wdata <= bus.mem_wdata;
            if (!bus.if_req)
              r_burst <= '0;
            else if (r_burst != BURST_MAX)
              r_burst <= r_burst + 1'b1;
          end else if (w_grant_if) begin
            r_state     <= ST_BUSY_IF;
            r_ram_en    <= 1'b1;
            r_ram_we    <= 1'b0;
            r_ram_size  <= SZ_WORD;
            r_ram_addr  <= bus.if_addr;
            r_ram_wdata <= '0;
            r_burst     <= '0;
          end else if (!bus.if_req) begin
            r_burst <= '0;
          end
        end
        ST_BUSY_IF: begin
          // The RAM read still runs to completion; only if_done is withheld.
          if (bus.if_flush) r_cancel <= 1'b1;
          if (w_last) r_state <= ST_IDLE;
        end
        ST_BUSY_MEM: begin
          if (w_last) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.if_done   = (r_state == ST_BUSY_IF) & w_last & ~r_cancel;
  assign bus.mem_done  = (r_state == ST_BUSY_MEM) & w_last;
  assign bus.if_rdata  = bus.ram_rdata;
  assign bus.mem_rdata = bus.ram_rdata;

  assign bus.ram_en    = r_ram_en;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_size  = r_ram_size;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;

  assign o_state = r_state;

endmodule

// File: tb/tb_pa_mem_arbiter.sv
// tb_pa_mem_arbiter: directed scenarios against a behavioural RAM model,
// with a done-driven scoreboard checking data and completion cycle.
module tb_pa_mem_arbiter;
  import pa_mem_pkg::*;

  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 32;
  localparam int LAT       = 2;
  localparam int MAX_BURST = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pa_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  state_e dut_state;

  pa_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .o_state (dut_state)
  );

  // ---------------- RAM model (little-endian byte lanes) ----------------
  logic [DATA_W-1:0] ram_arr [0:(1<<(ADDR_W-2))-1];
  logic [DATA_W-1:0] rd_pipe [0:LAT-1];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    case (sz)
      2'b00:   r[8*off +: 8]     = wd[7:0];
      2'b01:   r[16*off[1] +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.ram_en) begin
      rd_pipe[0] <= ram_arr[bus.ram_addr[ADDR_W-1:2]];
      if (bus.ram_we)
        ram_arr[bus.ram_addr[ADDR_W-1:2]] <= merge(ram_arr[bus.ram_addr[ADDR_W-1:2]],
                                                   bus.ram_wdata, bus.ram_size,
                                                   bus.ram_addr[1:0]);
    end
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.ram_rdata = rd_pipe[LAT-1];

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic              chk;
    logic [DATA_W-1:0] data;
    logic [31:0]       cyc;
  } exp_t;

  exp_t exp_if_q[$];
  exp_t exp_mem_q[$];
  exp_t mon_if_e;
  exp_t mon_mem_e;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (bus.if_done) begin
      if (exp_if_q.size() == 0) begin
        n_checks++;
        $display("FAIL if_done_unexpected: got if_done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_if_e = exp_if_q.pop_front();
        check("if_done_cycle", 64'(cyc), 64'(mon_if_e.cyc));
        check("if_rdata", 64'(bus.if_rdata), 64'(mon_if_e.data));
      end
    end
    if (bus.mem_done) begin
      if (exp_mem_q.size() == 0) begin
        n_checks++;
        $display("FAIL mem_done_unexpected: got mem_done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_mem_e = exp_mem_q.pop_front();
        check("mem_done_cycle", 64'(cyc), 64'(mon_mem_e.cyc));
        if (mon_mem_e.chk) check("mem_rdata", 64'(bus.mem_rdata), 64'(mon_mem_e.data));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic run_mem(input logic we, input logic [1:0] sz, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_d);
    int t0;
    tick();
    t0 = cyc;
    exp_mem_q.push_back(exp_t'{chk: !we, data: exp_d, cyc: 32'(t0 + LAT + 1)});
    bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_size = sz;
    bus.mem_addr = addr; bus.mem_wdata = wd;
    tick(); mid();
    check("mem_ram_en", 64'(bus.ram_en), 64'(1));
    check("mem_ram_we", 64'(bus.ram_we), 64'(we));
    check("mem_ram_size", 64'(bus.ram_size), 64'((sz == 2'b11) ? SZ_WORD : sz));
    check("mem_ram_addr", 64'(bus.ram_addr), 64'(addr));
    if (we) check("mem_ram_wdata", 64'(bus.ram_wdata), 64'(wd));
    tick(); tick();
    tick();
    bus.mem_req = 1'b0;
    mid();
    check("mem_turnaround_idle", 64'(dut_state), 64'(ST_IDLE));
  endtask

  task automatic run_if(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp_d);
    int t0;
    tick();
    t0 = cyc;
    exp_if_q.push_back(exp_t'{chk: 1'b1, data: exp_d, cyc: 32'(t0 + LAT + 1)});
    bus.if_req = 1'b1; bus.if_addr = addr;
    tick(); mid();
    check("if_ram_en", 64'(bus.ram_en), 64'(1));
    check("if_ram_we", 64'(bus.ram_we), 64'(0));
    check("if_ram_size", 64'(bus.ram_size), 64'(SZ_WORD));
    check("if_ram_addr", 64'(bus.ram_addr), 64'(addr));
    tick(); mid();
    check("if_ram_en_pulse", 64'(bus.ram_en), 64'(0));
    tick();
    tick();
    bus.if_req = 1'b0;
    mid();
    check("if_turnaround_idle", 64'(dut_state), 64'(ST_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  int t0;
  initial begin
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_size = SZ_WORD;
    bus.mem_addr = '0; bus.mem_wdata = '0;
    for (int i = 0; i < (1 << (ADDR_W - 2)); i++) ram_arr[i] = '0;
    ram_arr[1] = 32'hDEADBEEF;
    ram_arr[2] = 32'hCAFEF00D;

    // reset state
    repeat (2) @(posedge clk);
    mid();
    check("rst_state", 64'(dut_state), 64'(ST_IDLE));
    check("rst_ram_en", 64'(bus.ram_en), 64'(0));
    check("rst_ram_we", 64'(bus.ram_we), 64'(0));
    check("rst_ram_size", 64'(bus.ram_size), 64'(0));
    check("rst_ram_addr", 64'(bus.ram_addr), 64'(0));
    check("rst_ram_wdata", 64'(bus.ram_wdata), 64'(0));
    check("rst_if_done", 64'(bus.if_done), 64'(0));
    check("rst_mem_done", 64'(bus.mem_done), 64'(0));
    tick();
    reset = 1'b0;

    // IF only
    run_if(9'h004, 32'hDEADBEEF);

    // both in c0: MEM STW wins, IF granted at end of c4, done c7
    tick();
    t0 = cyc;
    exp_mem_q.push_back(exp_t'{chk: 1'b0, data: '0, cyc: 32'(t0 + 3)});
    exp_if_q.push_back(exp_t'{chk: 1'b1, data: 32'hCAFEF00D, cyc: 32'(t0 + 7)});
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_size = SZ_WORD;
    bus.mem_addr = 9'h010; bus.mem_wdata = 32'h12345678;
    bus.if_req = 1'b1; bus.if_addr = 9'h008;
    tick(); mid();
    check("both_ram_we", 64'(bus.ram_we), 64'(1));
    check("both_ram_size", 64'(bus.ram_size), 64'(SZ_WORD));
    check("both_ram_addr", 64'(bus.ram_addr), 64'(9'h010));
    check("both_ram_wdata", 64'(bus.ram_wdata), 64'(32'h12345678));
    tick(); tick();
    tick();
    bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    mid();
    check("both_c4_idle", 64'(dut_state), 64'(ST_IDLE));
    tick(); mid();
    check("both_if_ram_en", 64'(bus.ram_en), 64'(1));
    check("both_if_ram_addr", 64'(bus.ram_addr), 64'(9'h008));
    check("both_if_state", 64'(dut_state), 64'(ST_BUSY_IF));
    tick(); tick();
    tick();
    bus.if_req = 1'b0;

    // read back the stored word
    run_mem(1'b0, SZ_WORD, 9'h010, '0, 32'h12345678);

    // both held: 4 MEM, then 1 IF, then MEM again
    tick();
    t0 = cyc;
    for (int k = 0; k < 4; k++)
      exp_mem_q.push_back(exp_t'{chk: 1'b1, data: 32'h12345678, cyc: 32'(t0 + 3 + 4*k)});
    exp_if_q.push_back(exp_t'{chk: 1'b1, data: 32'hDEADBEEF, cyc: 32'(t0 + 19)});
    exp_mem_q.push_back(exp_t'{chk: 1'b1, data: 32'h12345678, cyc: 32'(t0 + 23)});
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = SZ_WORD; bus.mem_addr = 9'h010;
    bus.if_req = 1'b1; bus.if_addr = 9'h004;
    repeat (16) tick();
    mid();
    check("burst_c16_idle", 64'(dut_state), 64'(ST_IDLE));
    tick(); mid();
    check("burst_if_wins", 64'(dut_state), 64'(ST_BUSY_IF));
    repeat (7) tick();
    bus.mem_req = 1'b0; bus.if_req = 1'b0;
    mid();
    check("burst_end_idle", 64'(dut_state), 64'(ST_IDLE));

    // flush during IF: no if_done, pending MEM granted at end of c4
    tick();
    t0 = cyc;
    exp_mem_q.push_back(exp_t'{chk: 1'b1, data: 32'hCAFEF00D, cyc: 32'(t0 + 7)});
    bus.if_req = 1'b1; bus.if_addr = 9'h004;
    tick();
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = SZ_WORD; bus.mem_addr = 9'h008;
    tick();
    bus.if_flush = 1'b1; bus.if_req = 1'b0;
    tick();
    bus.if_flush = 1'b0;
    mid();
    check("flush_no_if_done", 64'(bus.if_done), 64'(0));
    check("flush_c3_busy_if", 64'(dut_state), 64'(ST_BUSY_IF));
    tick(); mid();
    check("flush_c4_idle", 64'(dut_state), 64'(ST_IDLE));
    tick(); mid();
    check("flush_mem_ram_en", 64'(bus.ram_en), 64'(1));
    check("flush_mem_ram_addr", 64'(bus.ram_addr), 64'(9'h008));
    tick(); tick();
    tick();
    bus.mem_req = 1'b0;

    // reset in c2 of a MEM load; re-held request completes after release
    tick();
    t0 = cyc;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = SZ_WORD; bus.mem_addr = 9'h004;
    tick(); mid();
    check("rstmid_busy", 64'(dut_state), 64'(ST_BUSY_MEM));
    tick();
    reset = 1'b1;
    #1;
    check("rstmid_state", 64'(dut_state), 64'(ST_IDLE));
    check("rstmid_ram_en", 64'(bus.ram_en), 64'(0));
    check("rstmid_ram_addr", 64'(bus.ram_addr), 64'(0));
    tick();
    tick();
    reset = 1'b0;
    exp_mem_q.push_back(exp_t'{chk: 1'b1, data: 32'hDEADBEEF, cyc: 32'(t0 + 7)});
    mid();
    check("rstmid_c4_idle", 64'(dut_state), 64'(ST_IDLE));
    tick(); mid();
    check("rstmid_regrant", 64'(bus.ram_en), 64'(1));
    tick(); tick();
    tick();
    bus.mem_req = 1'b0;

    // STB then LDW over the byte lane, and size 11 treated as word
    run_mem(1'b1, SZ_BYTE, 9'h021, 32'h000000AB, '0);
    run_mem(1'b0, SZ_WORD, 9'h020, '0, 32'h0000AB00);
    run_mem(1'b0, 2'b11, 9'h020, '0, 32'h0000AB00);

    tick(); tick();
    check("if_queue_empty", 64'(exp_if_q.size()), 64'(0));
    check("mem_queue_empty", 64'(exp_mem_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
